keypad_bcd_entry: RTL

//   Input-side counterpart of the 4-digit seven-segment display path.

---
 rtl/keypad_pkg.sv | 39 +++
 rtl/bcd_entry_reg.sv | 37 +++
 rtl/keypad_bcd_entry.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and the keypad layout for the keypad BCD entry path.
// Layout follows the Pmod KYPD matrix: row 0 is the top row, column 0 the leftmost.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] KEY_BSP = 4'hB;

  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'h0;
      4'hD: code = 4'hF;
      4'hE: code = 4'hE;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// 4-digit BCD entry register: digits shift in from the right, C clears, B deletes the LSD.
module bcd_entry_reg
  import keypad_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [3:0]  key_i,
  output logic [15:0] bcd_o
);

  logic [15:0] r_bcd;
  logic [15:0] w_bcd_next;

  // Letter keys other than C/B leave the register untouched.
  always_comb begin
    w_bcd_next = r_bcd;
    if (key_i <= 4'd9) begin
      w_bcd_next = {r_bcd[11:0], key_i};
    end else if (key_i == KEY_CLR) begin
      w_bcd_next = 16'h0000;
    end else if (key_i == KEY_BSP) begin
      w_bcd_next = {4'h0, r_bcd[15:4]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_bcd <= 16'h0000;
    end else if (load_i) begin
      r_bcd <= w_bcd_next;
    end
  end

  assign bcd_o = r_bcd;

endmodule

// File: rtl/keypad_bcd_entry.sv
// 4x4 keypad scanner with tick-based debounce, one event per press, feeding a BCD entry register.
module keypad_bcd_entry
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_PSC = 100000,
  parameter int unsigned DEB_N    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [3:0]  col_i,
  output logic [3:0]  row_o,
  output logic [3:0]  key_o,
  output logic        key_vld_o,
  output logic [15:0] bcd_o
);

  localparam int unsigned PSC_W = $clog2(SCAN_PSC);
  localparam int unsigned CNT_W = $clog2(DEB_N + 1);
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(SCAN_PSC - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_N - 1);

  logic [PSC_W-1:0] r_psc;
  logic [3:0]       r_col_meta;
  logic [3:0]       r_col_sync;
  logic [1:0]       r_row_idx;
  logic [3:0]       r_code;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_row;
  logic [3:0]       r_key;
  logic             r_key_vld;
  state_t           r_state;

  logic             w_tick;
  logic             w_key_any;
  logic [1:0]       w_col_idx;
  logic [3:0]       w_code;
  logic             w_same;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_row_adv;
  logic             w_latch;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_tick = en_i && (r_psc == PSC_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || !en_i) begin
      r_psc <= '0;
    end else if (w_tick) begin
      r_psc <= '0;
    end else begin
      r_psc <= r_psc + PSC_W'(1);
    end
  end

  // Columns are asynchronous to clk_i; two flops before anything decodes them.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_col_meta <= 4'hF;
      r_col_sync <= 4'hF;
    end else begin
      r_col_meta <= col_i;
      r_col_sync <= r_col_meta;
    end
  end

  assign w_key_any = ~&r_col_sync;

  always_comb begin
    w_col_idx = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (!r_col_sync[c]) w_col_idx = 2'(c);
    end
  end

  assign w_code = keymap(r_row_idx, w_col_idx);
  assign w_same = w_key_any && (w_code == r_code);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || !en_i) begin
      r_state <= SCAN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    if (w_tick) begin
      case (r_state)
        SCAN:     if (w_key_any) w_state_next = DEBOUNCE;
        DEBOUNCE: begin
          if (!w_same)                 w_state_next = SCAN;
          else if (r_cnt == CNT_LAST)  w_state_next = HELD;
        end
        HELD:     if (!w_key_any && (r_cnt == CNT_LAST)) w_state_next = SCAN;
        default:  w_state_next = SCAN;
      endcase
    end
  end

  // r_cnt counts matching samples in DEBOUNCE and all-high samples in HELD.
  always_comb begin
    w_accept   = 1'b0;
    w_row_adv  = 1'b0;
    w_latch    = 1'b0;
    w_cnt_next = r_cnt;
    if (w_tick) begin
      case (r_state)
        SCAN: begin
          if (w_key_any) begin
            w_latch    = 1'b1;
            w_cnt_next = CNT_W'(1);
          end else begin
            w_row_adv  = 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!w_same) begin
            w_row_adv  = 1'b1;
            w_cnt_next = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_accept   = 1'b1;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (w_key_any) begin
            w_cnt_next = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_row_adv  = 1'b1;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        default: w_cnt_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || !en_i) begin
      r_row_idx <= 2'd0;
      r_cnt     <= '0;
    end else begin
      if (w_row_adv) r_row_idx <= r_row_idx + 2'd1;
      r_cnt <= w_cnt_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_code <= 4'h0;
    end else if (w_latch) begin
      r_code <= w_code;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_row     <= 4'hF;
      r_key     <= 4'h0;
      r_key_vld <= 1'b0;
    end else begin
      r_row     <= en_i ? ~(4'b0001 << r_row_idx) : 4'hF;
      r_key_vld <= w_accept;
      if (w_accept) r_key <= r_code;
    end
  end

  bcd_entry_reg u_bcd_entry_reg (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (w_accept),
    .key_i  (r_code),
    .bcd_o  (bcd_o)
  );

  assign row_o     = r_row;
  assign key_o     = r_key;
  assign key_vld_o = r_key_vld;

endmodule
